lsu_ctrl: RTL and testbench

Multicycle load/store controller between the datapath's MEM stage and the 4 KB data memory. It accepts one request at a time and checks alignment. For stores it converts the operation type into the memory byte-enable code with a single write strobe. For loads it extracts and sign- or zero-extends the addressed byte, half or word, holding the result until the next request.

---
 rtl/lsu_ctrl_if.sv | 25 ++
 rtl/lsu_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Request-side bundle between the MEM stage and the load/store controller.
// Ports:
//   req, op[2:0], addr[31:0], wdata[31:0] : request from the datapath
//   busy, done, misalign, rdata[31:0]     : status and load result back
// Modports: master = datapath side, slave = lsu_ctrl side.
interface lsu_ctrl_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [31:0] rdata;

    modport master (
        output req, op, addr, wdata,
        input  busy, done, misalign, rdata
    );

    modport slave (
        input  req, op, addr, wdata,
        output busy, done, misalign, rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Multicycle load/store controller between the MEM stage and a 1024-word
// data memory. One request at a time: checks alignment, issues a single
// write strobe with a byte-enable code for stores, and extracts plus sign/
// zero-extends byte/half/word data for loads.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   bus (slave)       : req/op/addr/wdata in, busy/done/misalign/rdata out
//   dm_addr[9:0]      : memory word address (addr[11:2])
//   dm_din[31:0]      : memory write data, unshifted
//   dm_we             : write enable, gated by rst_n
//   dm_be[3:0]        : byte-enable code, non-zero only in ACCESS
//   dm_dout[31:0]     : combinational read data from memory
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    lsu_ctrl_if.slave   bus,
    output logic [9:0]  dm_addr,
    output logic [31:0] dm_din,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_dout
);
    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FIN    = 2'd2,
        ERR    = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_t;

    state_t          state;
    op_t             op_q;
    logic [1:0]      off_q;
    logic            store_q;
    logic            busy_q;
    logic            done_q;
    logic            mis_q;
    logic [DW-1:0]   rdata_q;
    logic [AW-1:0]   dm_addr_q;
    logic [DW-1:0]   dm_din_q;
    logic            we_q;
    logic [BEW-1:0]  be_q;

    op_t             req_op_c;
    logic            req_store_c;
    logic            req_mis_c;
    logic [BEW-1:0]  req_be_c;
    logic [15:0]     half_c;
    logic [7:0]      byte_c;
    logic [DW-1:0]   load_c;
    logic            unused_addr_hi;

    // Decode the incoming request: store flag, alignment fault, byte enables.
    always_comb begin
        req_op_c    = op_t'(bus.op);
        req_store_c = 1'b0;
        req_mis_c   = 1'b0;
        req_be_c    = 4'b1111;
        case (req_op_c)
            OP_LW: begin
                req_mis_c = (bus.addr[1:0] != 2'b00);
            end
            OP_LH, OP_LHU: begin
                req_mis_c = bus.addr[0];
            end
            OP_LB, OP_LBU: begin
                req_mis_c = 1'b0;
            end
            OP_SW: begin
                req_store_c = 1'b1;
                req_mis_c   = (bus.addr[1:0] != 2'b00);
            end
            OP_SH: begin
                req_store_c = 1'b1;
                req_mis_c   = bus.addr[0];
                req_be_c    = bus.addr[1] ? 4'b1100 : 4'b0011;
            end
            OP_SB: begin
                req_store_c = 1'b1;
                req_be_c    = 4'b0001 << bus.addr[1:0];
            end
            default: begin
                req_store_c = 1'b0;
            end
        endcase
    end

    // Select and extend the addressed lane of the memory read word.
    always_comb begin
        half_c = off_q[1] ? dm_dout[31:16] : dm_dout[15:0];
        byte_c = dm_dout[{off_q, 3'b000} +: 8];
        load_c = dm_dout;
        case (op_q)
            OP_LH:   load_c = {{16{half_c[15]}}, half_c};
            OP_LHU:  load_c = {16'h0000, half_c};
            OP_LB:   load_c = {{24{byte_c[7]}}, byte_c};
            OP_LBU:  load_c = {24'h000000, byte_c};
            default: load_c = dm_dout;
        endcase
    end

    // Controller state and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_LW;
            off_q     <= 2'b00;
            store_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mis_q     <= 1'b0;
            rdata_q   <= '0;
            dm_addr_q <= '0;
            dm_din_q  <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
        end else begin
            // Pulsed outputs fall back to idle unless set below.
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            we_q   <= 1'b0;
            be_q   <= '0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        op_q    <= req_op_c;
                        off_q   <= bus.addr[1:0];
                        store_q <= req_store_c;
                        busy_q  <= 1'b1;
                        if (req_mis_c) begin
                            // Abort: report in the very next cycle, no memory traffic.
                            state  <= ERR;
                            done_q <= 1'b1;
                            mis_q  <= 1'b1;
                        end else begin
                            // Memory port is presented during ACCESS from these copies.
                            state     <= ACCESS;
                            dm_addr_q <= bus.addr[11:2];
                            dm_din_q  <= bus.wdata;
                            we_q      <= req_store_c;
                            be_q      <= req_be_c;
                        end
                    end
                end
                ACCESS: begin
                    state  <= FIN;
                    done_q <= 1'b1;
                    if (!store_q) begin
                        rdata_q <= load_c;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                ERR: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Reset asserted during ACCESS must kill the write at that same edge.
    assign dm_we = we_q & rst_n;

    assign dm_addr      = dm_addr_q;
    assign dm_din       = dm_din_q;
    assign dm_be        = be_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.misalign = mis_q;
    assign bus.rdata    = rdata_q;

    assign unused_addr_hi = ^bus.addr[31:12];
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed, table-driven bench for lsu_ctrl with a byte-enable aware
// behavioural data memory.
module tb_lsu_ctrl;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk;
    logic        rst_n;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_dout;

    lsu_ctrl_if bus ();

    lsu_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .dm_addr (dm_addr),
        .dm_din  (dm_din),
        .dm_we   (dm_we),
        .dm_be   (dm_be),
        .dm_dout (dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: the byte-enable code says where the low data goes.
    logic [31:0] mem [1024] = '{default: 32'h0};
    int          wr_cnt   = 0;
    logic [31:0] last_din = 32'h0;
    int          bad_be   = 0;

    assign dm_dout = mem[dm_addr];

    always @(posedge clk) begin
        if (dm_we) begin
            wr_cnt   <= wr_cnt + 1;
            last_din <= dm_din;
            case (dm_be)
                4'b1111: mem[dm_addr]        <= dm_din;
                4'b0011: mem[dm_addr][15:0]  <= dm_din[15:0];
                4'b1100: mem[dm_addr][31:16] <= dm_din[15:0];
                4'b0001: mem[dm_addr][7:0]   <= dm_din[7:0];
                4'b0010: mem[dm_addr][15:8]  <= dm_din[7:0];
                4'b0100: mem[dm_addr][23:16] <= dm_din[7:0];
                4'b1000: mem[dm_addr][31:24] <= dm_din[7:0];
                default: bad_be <= bad_be + 1;
            endcase
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},     32'(bus.busy),     32'h0);
        check({tag, " done"},     32'(bus.done),     32'h0);
        check({tag, " misalign"}, 32'(bus.misalign), 32'h0);
        check({tag, " rdata"},    bus.rdata,         32'h0);
        check({tag, " dm_we"},    32'(dm_we),        32'h0);
        check({tag, " dm_be"},    32'(dm_be),        32'h0);
        check({tag, " dm_addr"},  32'(dm_addr),      32'h0);
        check({tag, " dm_din"},   dm_din,            32'h0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mis;
        logic [3:0]  be;
        logic        we;
        logic [31:0] rdata;
    } vec_t;

    // Issue one request at a negedge and follow it to completion.
    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        int          w0;
        logic [3:0]  be_seen;
        logic [9:0]  a_seen;
        logic        mis_seen;
        logic [9:0]  exp_waddr;
        w0        = wr_cnt;
        lat       = 0;
        be_seen   = 4'h0;
        a_seen    = 10'h0;
        mis_seen  = 1'b0;
        exp_waddr = v.addr[11:2];
        bus.req   = 1'b1;
        bus.op    = v.op;
        bus.addr  = v.addr;
        bus.wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs so only the latched copies can produce the result.
        bus.req   = 1'b0;
        bus.op    = ~v.op;
        bus.addr  = v.addr ^ 32'h0000_0FFF;
        bus.wdata = ~v.wdata;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            if (dm_be != 4'h0) begin
                be_seen = dm_be;
                a_seen  = dm_addr;
            end
            if (bus.done) begin
                lat      = c;
                mis_seen = bus.misalign;
                break;
            end
        end
        check($sformatf("v%0d latency", idx), 32'(lat), v.mis ? 32'd1 : 32'd2);
        check($sformatf("v%0d misalign", idx), 32'(mis_seen), 32'(v.mis));
        check($sformatf("v%0d rdata", idx), bus.rdata, v.rdata);
        check($sformatf("v%0d dm_be", idx), 32'(be_seen), 32'(v.be));
        check($sformatf("v%0d writes", idx), 32'(wr_cnt - w0), 32'(v.we));
        if (!v.mis) check($sformatf("v%0d dm_addr", idx), 32'(a_seen), 32'(exp_waddr));
        if (v.we) check($sformatf("v%0d dm_din", idx), last_din, v.wdata);
        @(negedge clk);
        check($sformatf("v%0d busy_after", idx), 32'(bus.busy), 32'h0);
    endtask

    vec_t vecs [20];

    initial begin
        int          w0;
        int          ndone;
        logic [8:0]  done_pat;
        logic [8:0]  busy_pat;

        rst_n     = 1'b0;
        bus.req   = 1'b0;
        bus.op    = 3'd0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;

        // Reset values.
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Reset during ACCESS of SW 0x010 drops the write.
        w0        = wr_cnt;
        bus.req   = 1'b1;
        bus.op    = SW;
        bus.addr  = 32'h0000_0010;
        bus.wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        check("racc we_before", 32'(dm_we), 32'h1);
        check("racc busy", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("racc we_gated", 32'(dm_we), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("racc");
        check("racc no_write", 32'(wr_cnt - w0), 32'h0);
        check("racc word4", mem[4], 32'h0);
        @(negedge clk);
        check("racc idle_done", 32'(bus.done), 32'h0);

        // op, addr, wdata, misalign, be, we, rdata-after
        vecs[0]  = '{SW,  32'h0000_0004, 32'h1122_3344, 1'b0, 4'b1111, 1'b1, 32'h0000_0000};
        vecs[1]  = '{LW,  32'h0000_0004, 32'h0,         1'b0, 4'b1111, 1'b0, 32'h1122_3344};
        vecs[2]  = '{SB,  32'h0000_0006, 32'h0000_00AA, 1'b0, 4'b0100, 1'b1, 32'h1122_3344};
        vecs[3]  = '{LB,  32'h0000_0006, 32'h0,         1'b0, 4'b1111, 1'b0, 32'hFFFF_FFAA};
        vecs[4]  = '{LBU, 32'h0000_0006, 32'h0,         1'b0, 4'b1111, 1'b0, 32'h0000_00AA};
        vecs[5]  = '{LW,  32'h0000_0004, 32'h0,         1'b0, 4'b1111, 1'b0, 32'h11AA_3344};
        vecs[6]  = '{SH,  32'h0000_000A, 32'h0000_8001, 1'b0, 4'b1100, 1'b1, 32'h11AA_3344};
        vecs[7]  = '{LH,  32'h0000_000A, 32'h0,         1'b0, 4'b1111, 1'b0, 32'hFFFF_8001};
        vecs[8]  = '{LHU, 32'h0000_000A, 32'h0,         1'b0, 4'b1111, 1'b0, 32'h0000_8001};
        vecs[9]  = '{LW,  32'h0000_0002, 32'h0,         1'b1, 4'b0000, 1'b0, 32'h0000_8001};
        vecs[10] = '{SH,  32'h0000_0003, 32'h5555_5555, 1'b1, 4'b0000, 1'b0, 32'h0000_8001};
        vecs[11] = '{LB,  32'h0000_0005, 32'h0,         1'b0, 4'b1111, 1'b0, 32'h0000_0033};
        vecs[12] = '{LH,  32'h0000_0004, 32'h0,         1'b0, 4'b1111, 1'b0, 32'h0000_3344};
        vecs[13] = '{SB,  32'h0000_000B, 32'hFFFF_FF7F, 1'b0, 4'b1000, 1'b1, 32'h0000_3344};
        vecs[14] = '{LB,  32'h0000_000B, 32'h0,         1'b0, 4'b1111, 1'b0, 32'h0000_007F};
        vecs[15] = '{SB,  32'h0000_0008, 32'h1234_5680, 1'b0, 4'b0001, 1'b1, 32'h0000_007F};
        vecs[16] = '{LB,  32'h0000_0008, 32'h0,         1'b0, 4'b1111, 1'b0, 32'hFFFF_FF80};
        vecs[17] = '{LH,  32'h0000_0001, 32'h0,         1'b1, 4'b0000, 1'b0, 32'hFFFF_FF80};
        vecs[18] = '{SW,  32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b0, 4'b1111, 1'b1, 32'hFFFF_FF80};
        vecs[19] = '{LW,  32'h0000_0FFC, 32'h0,         1'b0, 4'b1111, 1'b0, 32'hDEAD_BEEF};

        for (int i = 0; i < 20; i++) begin
            run_vec(vecs[i], i);
        end
        check("mem word2", mem[2], 32'h7F01_0080);
        check("bad_be", 32'(bad_be), 32'h0);

        // req held high: LW 0x004 completes every 3 cycles.
        done_pat  = 9'h0;
        busy_pat  = 9'h0;
        bus.req   = 1'b1;
        bus.op    = LW;
        bus.addr  = 32'h0000_0004;
        bus.wdata = 32'h0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            done_pat[c-1] = bus.done;
            busy_pat[c-1] = bus.busy;
        end
        bus.req = 1'b0;
        check("b2b done_pattern", 32'(done_pat), 32'h092);
        check("b2b busy_pattern", 32'(busy_pat), 32'h0DB);
        check("b2b rdata", bus.rdata, 32'h11AA_3344);
        repeat (2) @(negedge clk);

        // req pulsed during FIN is dropped, not queued.
        bus.req  = 1'b1;
        bus.op   = LBU;
        bus.addr = 32'h0000_0006;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        check("fin done", 32'(bus.done), 32'h1);
        check("fin rdata", bus.rdata, 32'h0000_00AA);
        w0        = wr_cnt;
        bus.req   = 1'b1;
        bus.op    = SW;
        bus.addr  = 32'h0000_0004;
        bus.wdata = 32'h0;
        @(negedge clk);
        bus.req = 1'b0;
        ndone   = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.done || bus.busy) ndone++;
            @(negedge clk);
        end
        check("fin ignored_activity", 32'(ndone), 32'h0);
        check("fin ignored_writes", 32'(wr_cnt - w0), 32'h0);
        check("fin word1", mem[1], 32'h11AA_3344);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
